serial_tx: RTL and testbench

Parallel-to-serial transmitter that sits directly downstream of the 8-bit data register. It accepts the register's parallel output through a valid/ready handshake and drives it onto a single-wire line as a framed word: a start bit, the data bits, an optional even-parity bit, then a stop bit. Bit order is selectable per word. Each bit is held for a programmable number of clock cycles.

---
 rtl/ser_pkg.sv | 22 ++
 rtl/serial_tx_bit_timer.sv | 43 ++++
 rtl/serial_tx.sv | 139 +++++++++++++
 tb/tb_serial_tx.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/ser_pkg.sv
// Shared constants for the serial transmitter: FSM state codes, line levels
// and a helper that sizes the small counters.
package ser_pkg;

    // FSM state codes
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;

    // Line levels
    localparam logic LINE_IDLE = 1'b1;
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

    // Counter width able to hold 0..n-1, never narrower than one bit
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/serial_tx_bit_timer.sv
// Per-bit cycle counter: counts 0..DIV-1 while running, held at zero by clear.
// tick marks the last cycle of a line bit.
module bit_timer
    import ser_pkg::*;
#(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);

    localparam int            TW   = cnt_width(DIV);
    localparam logic [TW-1:0] LAST = TW'(DIV - 1);

    logic [TW-1:0] cnt_q;
    logic [TW-1:0] cnt_d;

    // Next count: hold at zero when cleared, wrap after the last cycle of a bit
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (cnt_q == LAST) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + TW'(1);
        end
    end

    // Count register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = (cnt_q == LAST);

endmodule

// File: rtl/serial_tx.sv
// Parallel-to-serial transmitter: start bit, WIDTH data bits (order chosen per
// word), optional even parity, stop bit; each bit held DIV cycles.
module serial_tx
    import ser_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int DIV       = 4,
    parameter int PARITY_EN = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i,
    input  logic             i_valid,
    output logic             i_ready,
    input  logic             msb_first,
    output logic             so,
    output logic             busy,
    output logic             done
);

    localparam int            IW       = cnt_width(WIDTH);
    localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);

    logic [2:0]       state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic             par_q, par_d;
    logic             so_q, so_d;
    logic [WIDTH-1:0] rev_s;
    logic             tick_s;

    bit_timer #(.DIV(DIV)) u_timer (
        .clk   (clk),
        .rst   (rst),
        .clear (state_q == ST_IDLE),
        .tick  (tick_s)
    );

    // Bit-reversed copy of the input so shifting is always towards bit 0
    always_comb begin
        rev_s = '0;
        for (int k = 0; k < WIDTH; k++) begin
            rev_s[k] = i[WIDTH-1-k];
        end
    end

    // Frame sequencing, word capture and shifting
    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        idx_d   = idx_q;
        par_d   = par_q;
        case (state_q)
            ST_IDLE: begin
                if (i_valid) begin
                    state_d = ST_START;
                    shreg_d = msb_first ? rev_s : i;
                    par_d   = ^i;
                    idx_d   = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_START: begin
                if (tick_s) begin
                    state_d = ST_DATA;
                end else begin
                    state_d = ST_START;
                end
            end
            ST_DATA: begin
                if (tick_s) begin
                    shreg_d = shreg_q >> 1;
                    if (idx_q == LAST_IDX) begin
                        idx_d   = '0;
                        state_d = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end else begin
                    state_d = ST_DATA;
                end
            end
            ST_PARITY: begin
                if (tick_s) begin
                    state_d = ST_STOP;
                end else begin
                    state_d = ST_PARITY;
                end
            end
            ST_STOP: begin
                if (tick_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_STOP;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Line level for the coming cycle, registered so so is glitch-free
    always_comb begin
        so_d = LINE_IDLE;
        case (state_d)
            ST_IDLE:   so_d = LINE_IDLE;
            ST_START:  so_d = START_BIT;
            ST_DATA:   so_d = shreg_d[0];
            ST_PARITY: so_d = par_d;
            ST_STOP:   so_d = STOP_BIT;
            default:   so_d = LINE_IDLE;
        endcase
    end

    // State registers; reset aborts any frame in progress
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            shreg_q <= '0;
            idx_q   <= '0;
            par_q   <= 1'b0;
            so_q    <= LINE_IDLE;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            idx_q   <= idx_d;
            par_q   <= par_d;
            so_q    <= so_d;
        end
    end

    assign so      = so_q;
    assign busy    = (state_q != ST_IDLE);
    assign i_ready = (state_q == ST_IDLE) && !rst;
    assign done    = (state_q == ST_STOP) && tick_s;

endmodule

// File: tb/tb_serial_tx.sv
// Scoreboard bench for serial_tx: drivers push model frames at each handshake,
// line monitors collect so over each busy period and compare on done.
module tb_serial_tx;

    typedef struct {
        logic [63:0] bits;
        int          len;
    } frame_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] i1 = 8'h00, i2 = 8'h00;
    logic       v1 = 1'b0, v2 = 1'b0, m1 = 1'b0, m2 = 1'b0;
    logic       r1, so1, b1, d1;
    logic       r2, so2, b2, d2;

    frame_t q1[$];
    frame_t q2[$];
    int     vecs = 0;
    int     errs = 0;
    logic   gap_chk = 1'b0;

    always #5 clk = ~clk;

    serial_tx #(.WIDTH(8), .DIV(4), .PARITY_EN(1)) dut (
        .clk(clk), .rst(rst), .i(i1), .i_valid(v1), .i_ready(r1),
        .msb_first(m1), .so(so1), .busy(b1), .done(d1)
    );

    serial_tx #(.WIDTH(8), .DIV(1), .PARITY_EN(0)) dut2 (
        .clk(clk), .rst(rst), .i(i2), .i_valid(v2), .i_ready(r2),
        .msb_first(m2), .so(so2), .busy(b2), .done(d2)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference frame: list of line bits, each repeated div times
    function automatic frame_t model(input logic [7:0] d, input logic msb, input int div, input int pen);
        frame_t f;
        logic   seq[$];
        int     ones;
        ones = 0;
        seq.push_back(1'b0);
        for (int k = 0; k < 8; k++) begin
            seq.push_back(msb ? d[7-k] : d[k]);
            ones += int'(d[k]);
        end
        if (pen != 0) seq.push_back(ones % 2 == 1);
        seq.push_back(1'b1);
        f.bits = '0;
        f.len  = 0;
        foreach (seq[j]) begin
            for (int r = 0; r < div; r++) begin
                f.bits[f.len] = seq[j];
                f.len++;
            end
        end
        return f;
    endfunction

    task automatic send1(input logic [7:0] d, input logic m, input logic [7:0] junk);
        int t;
        t = 0;
        @(negedge clk);
        i1 = d; m1 = m; v1 = 1'b1;
        while (!r1 && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!r1) begin
            check("handshake1 timeout", 64'd0, 64'd1);
            v1 = 1'b0;
            return;
        end
        q1.push_back(model(d, m, 4, 1));
        @(posedge clk);
        #1;
        v1 = 1'b0; i1 = junk; m1 = ~m;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((q1.size() != 0 || q2.size() != 0 || b1 || b2) && t < 500) begin
            @(negedge clk);
            t++;
        end
        check("drain", 64'(q1.size() + q2.size()), 64'd0);
    endtask

    // Monitor for the DIV=4, parity configuration
    initial begin
        logic [63:0] buf1;
        int          n1;
        logic        rdy_chk;
        frame_t      e;
        buf1 = '0; n1 = 0; rdy_chk = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                buf1 = '0; n1 = 0; rdy_chk = 1'b0;
                q1.delete();
            end else begin
                if (rdy_chk) begin
                    check("ready after done", {62'd0, b1, r1}, 64'd1);
                    rdy_chk = 1'b0;
                end
                if (b1) begin
                    if (n1 < 64) buf1[n1] = so1;
                    n1++;
                    if (d1) begin
                        if (q1.size() == 0) begin
                            check("unexpected done1", 64'd1, 64'd0);
                        end else begin
                            e = q1.pop_front();
                            check("frame1 bits", buf1, e.bits);
                            check("frame1 len", 64'(n1), 64'(e.len));
                        end
                        buf1 = '0; n1 = 0; rdy_chk = 1'b1;
                    end
                end else begin
                    check("idle1 line", {62'd0, so1, d1}, 64'd2);
                end
            end
        end
    end

    // Monitor for the DIV=1, no-parity configuration, including inter-frame gap
    initial begin
        logic [63:0] buf2;
        int          n2;
        int          idle2;
        frame_t      e;
        buf2 = '0; n2 = 0; idle2 = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                buf2 = '0; n2 = 0; idle2 = 0;
                q2.delete();
            end else if (b2) begin
                if (n2 == 0 && gap_chk) begin
                    check("b2b idle gap", 64'(idle2), 64'd1);
                    gap_chk = 1'b0;
                end
                if (n2 < 64) buf2[n2] = so2;
                n2++;
                if (d2) begin
                    if (q2.size() == 0) begin
                        check("unexpected done2", 64'd1, 64'd0);
                    end else begin
                        e = q2.pop_front();
                        check("frame2 bits", buf2, e.bits);
                        check("frame2 len", 64'(n2), 64'(e.len));
                    end
                    buf2 = '0; n2 = 0; idle2 = 0;
                end
            end else begin
                idle2++;
                check("idle2 line", {62'd0, so2, d2}, 64'd2);
            end
        end
    end

    // Stimulus
    initial begin
        int t;
        #12;
        check("reset dut1", {60'd0, so1, r1, b1, d1}, 64'h8);
        check("reset dut2", {60'd0, so2, r2, b2, d2}, 64'h8);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            check("idle ready", {62'd0, r1, so1}, 64'd3);
        end

        send1(8'hA5, 1'b1, 8'(($urandom)));
        send1(8'h01, 1'b0, 8'hFF);
        for (int k = 0; k < 20; k++) begin
            send1(8'($urandom), 1'($urandom), 8'($urandom));
        end
        drain();

        // Reset during DATA bit 3 (0x96 lsb-first: bit 3 is 0)
        send1(8'h96, 1'b0, 8'h69);
        repeat (17) @(negedge clk);
        check("pre-reset so", {63'd0, so1}, 64'd0);
        #2;
        rst = 1'b1;
        #1;
        check("async reset", {60'd0, so1, b1, r1, d1}, 64'h8);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        send1(8'h5A, 1'b0, 8'hA5);
        drain();

        // Back-to-back frames on the DIV=1 instance with i_valid held high
        @(negedge clk);
        i2 = 8'hC3; m2 = 1'b0; v2 = 1'b1;
        for (int f = 0; f < 2; f++) begin
            t = 0;
            while (!r2 && t < 100) begin
                @(negedge clk);
                t++;
            end
            if (!r2) check("handshake2 timeout", 64'd0, 64'd1);
            q2.push_back(model(i2, m2, 1, 0));
            @(posedge clk);
            #1;
            if (f == 0) begin
                i2 = 8'h3C;
            end else begin
                gap_chk = 1'b1;
                v2 = 1'b0;
                i2 = 8'hFF;
            end
        end
        drain();
        check("gap checked", {63'd0, gap_chk}, 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
